program_loader: RTL and testbench

Upstream of the instruction-fetch stage: turns the byte stream from the UART receiver into the program-loader interface that fetch consumes (`input_data`, `input_start`, `input_end`, toggle-style `input_valid`). Each program frame is a 4-byte big-endian word count N followed by N big-endian 32-bit instruction words. The block pulses `input_start` after the header, toggles `input_valid` once per assembled word, and pulses `input_end` after a drain interval. The drain interval lets fetch commit the last word before it re-enables execution.

---
 rtl/program_loader.sv | 177 +++++++++++++++++
 tb/tb_program_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: turns the UART byte stream into framed program words for instruction fetch.
// Frame = 4-byte big-endian word count N, then N big-endian 32-bit words.
module program_loader #(
  parameter int unsigned END_DELAY      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] input_data,
  output logic        input_start,
  output logic        input_end,
  output logic        input_valid,
  output logic        loading,
  output logic        load_error
);

  localparam int unsigned IdleW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DrainW = $clog2(END_DELAY);

  localparam logic [IdleW-1:0]  IdleLast  = IdleW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdleW-1:0]  IdleOne   = IdleW'(1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(END_DELAY - 1);
  localparam logic [DrainW-1:0] DrainOne  = DrainW'(1);

  typedef enum logic [2:0] {StHdr, StStart, StData, StDrain, StEnd} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  // Only the three earlier bytes are held; the fourth comes straight from rx_data.
  logic [23:0]       sr_q, sr_d;
  logic [31:0]       count_q, count_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [31:0]       data_q, data_d;
  logic              start_q, start_d;
  logic              end_q, end_d;
  logic              valid_q, valid_d;
  logic              loading_q, loading_d;
  logic              error_q, error_d;

  logic        accept;
  logic        counting;
  logic        word_done;
  logic        timeout;
  logic [31:0] word;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sr_d      = sr_q;
    count_d   = count_q;
    idle_d    = idle_q;
    drain_d   = drain_q;
    data_d    = data_q;
    start_d   = 1'b0;
    end_d     = 1'b0;
    valid_d   = valid_q;
    loading_d = loading_q;
    error_d   = error_q;

    accept    = rx_valid && ((state_q == StHdr) || (state_q == StStart) || (state_q == StData));
    word      = {sr_q, rx_data};
    word_done = accept && (idx_q == 2'd3);
    counting  = (state_q == StData) || ((state_q == StHdr) && (idx_q != 2'd0));
    timeout   = counting && !rx_valid && (idle_q == IdleLast);

    if (accept) begin
      sr_d  = word[23:0];
      idx_d = idx_q + 2'd1;
    end

    if (rx_valid) begin
      idle_d = '0;
    end else if (counting) begin
      idle_d = idle_q + IdleOne;
    end else begin
      idle_d = '0;
    end

    unique case (state_q)
      StHdr: begin
        if (word_done) begin
          count_d   = word;
          error_d   = 1'b0;
          start_d   = 1'b1;
          loading_d = 1'b1;
          state_d   = StStart;
        end else if (timeout) begin
          idx_d  = 2'd0;
          idle_d = '0;
        end
      end
      StStart: begin
        if (count_q == 32'd0) begin
          // Empty program: any byte strobed here is dropped along with DRAIN traffic.
          idx_d   = 2'd0;
          drain_d = '0;
          state_d = StDrain;
        end else begin
          state_d = StData;
        end
      end
      StData: begin
        if (word_done) begin
          data_d  = word;
          valid_d = ~valid_q;
          count_d = count_q - 32'd1;
          if (count_q == 32'd1) begin
            drain_d = '0;
            state_d = StDrain;
          end
        end else if (timeout) begin
          idx_d   = 2'd0;
          idle_d  = '0;
          error_d = 1'b1;
          drain_d = '0;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          end_d   = 1'b1;
          state_d = StEnd;
        end else begin
          drain_d = drain_q + DrainOne;
        end
      end
      StEnd: begin
        loading_d = 1'b0;
        state_d   = StHdr;
      end
      default: begin
        state_d = StHdr;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= StHdr;
      idx_q     <= 2'd0;
      sr_q      <= '0;
      count_q   <= '0;
      idle_q    <= '0;
      drain_q   <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      valid_q   <= 1'b0;
      loading_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      count_q   <= count_d;
      idle_q    <= idle_d;
      drain_q   <= drain_d;
      data_q    <= data_d;
      start_q   <= start_d;
      end_q     <= end_d;
      valid_q   <= valid_d;
      loading_q <= loading_d;
      error_q   <= error_d;
    end
  end

  assign input_data  = data_q;
  assign input_start = start_q;
  assign input_end   = end_q;
  assign input_valid = valid_q;
  assign loading     = loading_q;
  assign load_error  = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and randomized frames for program_loader, checked every cycle
// against a frame-level model built from byte queues and event timestamps.
module tb_program_loader;

  localparam int unsigned ED = 5;
  localparam int unsigned TO = 64;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] input_data;
  logic        input_start, input_end, input_valid, loading, load_error;

  program_loader #(
    .END_DELAY     (ED),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .input_data (input_data),
    .input_start(input_start),
    .input_end  (input_end),
    .input_valid(input_valid),
    .loading    (loading),
    .load_error (load_error)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {PhHdr, PhStart, PhData, PhDrain, PhEnd} phase_e;

  phase_e      mph = PhHdr;
  logic [7:0]  mq[$];
  longint      m_left = 0;
  int          m_idle = 0;
  longint      m_end_at = 0;
  longint      cyc = 0;
  logic [31:0] e_data = '0;
  logic        e_start = 0, e_end = 0, e_valid = 0, e_loading = 0, e_error = 0;

  task automatic model_reset();
    mph = PhHdr; mq.delete(); m_left = 0; m_idle = 0;
    e_data = '0; e_start = 0; e_end = 0; e_valid = 0; e_loading = 0; e_error = 0;
  endtask

  // Advances the model across one rising edge; cyc is the cycle that edge begins.
  task automatic model_step(input logic v, input logic [7:0] d);
    e_start = 0;
    e_end   = 0;
    if (v) m_idle = 0;
    case (mph)
      PhHdr: begin
        if (v) begin
          mq.push_back(d);
          if (mq.size() == 4) begin
            m_left = {mq[0], mq[1], mq[2], mq[3]};
            mq.delete();
            e_error = 0; e_start = 1; e_loading = 1; mph = PhStart;
          end
        end else if (mq.size() != 0) begin
          m_idle++;
          if (m_idle == TO) mq.delete();
        end
      end
      PhStart: begin
        if (m_left == 0) begin
          mph = PhDrain; m_end_at = cyc + ED;
        end else begin
          if (v) mq.push_back(d);
          mph = PhData;
        end
      end
      PhData: begin
        if (v) begin
          mq.push_back(d);
          if (mq.size() == 4) begin
            e_data = {mq[0], mq[1], mq[2], mq[3]};
            mq.delete();
            e_valid = !e_valid;
            m_left--;
            if (m_left == 0) begin mph = PhDrain; m_end_at = cyc + ED; end
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            mq.delete(); e_error = 1; mph = PhDrain; m_end_at = cyc + ED;
          end
        end
      end
      PhDrain: if (cyc == m_end_at) begin e_end = 1; mph = PhEnd; end
      PhEnd:   begin e_loading = 0; mph = PhHdr; end
      default: mph = PhHdr;
    endcase
  endtask

  // ---------------- event log ----------------
  int          n_start = 0, n_end = 0, n_tog = 0;
  longint      start_cyc = 0, end_cyc = 0, tog_cyc = 0, err_cyc = 0, last_rx_cyc = 0;
  logic [31:0] words[$];
  logic        prev_valid = 0, prev_err = 0;

  task automatic clear_log();
    n_start = 0; n_end = 0; n_tog = 0; words.delete();
  endtask

  always @(posedge CLK) begin
    cyc++;
    if (!reset) model_reset();
    else begin
      if (rx_valid) last_rx_cyc = cyc - 1;
      model_step(rx_valid, rx_data);
    end
    #1;
    chk($sformatf("cycle %0d outputs {start,end,valid,loading,error,data}", cyc),
        {27'd0, input_start, input_end, input_valid, loading, load_error, input_data},
        {27'd0, e_start, e_end, e_valid, e_loading, e_error, e_data});
    if (reset) begin
      if (input_start) begin n_start++; start_cyc = cyc; end
      if (input_end) begin n_end++; end_cyc = cyc; end
      if (input_valid !== prev_valid) begin n_tog++; tog_cyc = cyc; words.push_back(input_data); end
      if (load_error && !prev_err) err_cyc = cyc;
    end
    prev_valid = input_valid;
    prev_err   = load_error;
  end

  // ---------------- stimulus ----------------
  task automatic strobe(input logic [7:0] b);
    @(negedge CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge CLK);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    strobe(b);
    repeat ($urandom_range(1, 3)) @(negedge CLK);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  logic [31:0] w0, w1;
  int          kind, n;

  initial begin
    reset = 1'b0;
    idle(3);
    chk("reset_outputs", {27'd0, input_start, input_end, input_valid, loading, load_error,
        input_data}, 64'd0);
    reset = 1'b1;
    idle(2);

    // Empty program straight out of reset.
    clear_log();
    send_word(32'd0);
    idle(ED + 6);
    chk("n0_starts", n_start, 1);
    chk("n0_ends", n_end, 1);
    chk("n0_end_gap", end_cyc - start_cyc, ED + 1);
    chk("n0_toggles", n_tog, 0);
    chk("n0_data", input_data, 32'h0);

    // Two-word program.
    clear_log();
    send_word(32'd2);
    send_word(32'hDEADBEEF);
    send_word(32'h01234567);
    idle(ED + 6);
    chk("t1_starts", n_start, 1);
    chk("t1_toggles", n_tog, 2);
    chk("t1_word0", words[0], 32'hDEADBEEF);
    chk("t1_word1", words[1], 32'h01234567);
    chk("t1_end_gap", end_cyc - tog_cyc, ED);
    chk("t1_ends", n_end, 1);
    chk("t1_error", load_error, 0);

    // DATA timeout after one word and two stray bytes.
    clear_log();
    w0 = $urandom;
    send_word(32'd3);
    send_word(w0);
    send_byte(8'h5A);
    send_byte(8'hC3);
    idle(TO + ED + 8);
    chk("to_toggles", n_tog, 1);
    chk("to_word0", words[0], w0);
    chk("to_error", load_error, 1);
    chk("to_err_latency", err_cyc - last_rx_cyc, TO + 1);
    chk("to_end_gap", end_cyc - err_cyc, ED);
    chk("to_ends", n_end, 1);
    clear_log();
    send_word(32'd1);
    chk("to_err_cleared", load_error, 0);
    w1 = $urandom;
    send_word(w1);
    idle(ED + 6);
    chk("to_recover_word", words[0], w1);
    chk("to_recover_ends", n_end, 1);

    // Bytes strobed in DRAIN and END are dropped.
    clear_log();
    w0 = $urandom;
    send_word(32'd1);
    send_byte(w0[31:24]);
    send_byte(w0[23:16]);
    send_byte(w0[15:8]);
    strobe(w0[7:0]);
    @(negedge CLK);
    strobe(8'hAA);
    @(negedge CLK);
    strobe(8'hBB);
    idle(3);
    chk("drop_toggles", n_tog, 1);
    chk("drop_word", words[0], w0);
    chk("drop_ends", n_end, 1);
    clear_log();
    w1 = $urandom;
    send_word(32'd1);
    send_word(w1);
    idle(ED + 6);
    chk("drop_next_starts", n_start, 1);
    chk("drop_next_word", words[0], w1);
    chk("drop_next_toggles", n_tog, 1);

    // Reset in the middle of the second word of an N=4 load.
    clear_log();
    send_word(32'd4);
    send_word($urandom);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("pre_rst_valid", input_valid, 1);
    chk("pre_rst_loading", loading, 1);
    @(posedge CLK);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_async_outputs", {27'd0, input_start, input_end, input_valid, loading, load_error,
        input_data}, 64'd0);
    idle(2);
    reset = 1'b1;
    idle(2);
    clear_log();
    w0 = $urandom;
    w1 = $urandom;
    send_word(32'd2);
    send_word(w0);
    chk("post_rst_first_valid", input_valid, 1);
    send_word(w1);
    idle(ED + 6);
    chk("post_rst_toggles", n_tog, 2);
    chk("post_rst_word0", words[0], w0);
    chk("post_rst_word1", words[1], w1);
    chk("post_rst_ends", n_end, 1);

    // Back-to-back single-word frames.
    clear_log();
    send_word(32'd1);
    send_word(32'h11111111);
    idle(ED + 3);
    send_word(32'd1);
    send_word(32'h22222222);
    idle(ED + 6);
    chk("b2b_starts", n_start, 2);
    chk("b2b_ends", n_end, 2);
    chk("b2b_toggles", n_tog, 2);
    chk("b2b_word0", words[0], 32'h11111111);
    chk("b2b_word1", words[1], 32'h22222222);

    // Random frames, abandoned words, partial headers and short inter-frame gaps.
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        repeat ($urandom_range(1, 3)) send_byte(8'($urandom));
        idle(TO + 4);
      end else begin
        n = $urandom_range(0, 3);
        send_word(32'(n));
        for (int k = 0; k < n; k++) send_word($urandom);
        if (kind == 1) begin
          send_byte(8'($urandom));
          idle(TO + ED + 4);
        end
        idle($urandom_range(0, ED + 4));
      end
    end
    idle(TO + ED + 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
